// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one synchronous single-port SRAM between the
//               instruction-fetch (IF) and load/store (MEM) requesters.
//               Data-first priority with a starvation guard for fetch.
//               Read data is returned to its owner one cycle after the grant
//               and held stable until that owner's next grant.
//               Optional macro ARB_PERF_CNT_EN adds conflict / forced-grant
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_conflict_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    // Owner of the access whose response arrives in the current cycle
    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_inst = 2'd1;
    localparam logic [1:0] c_own_rd   = 2'd2;
    localparam logic [1:0] c_own_wr   = 2'd3;

    logic [3:0]  r_starve_cnt;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner_nxt;
    logic [31:0] r_inst_hold;
    logic [31:0] r_data_hold;
    logic        w_both_req;
    logic        w_force_if;
    logic        w_inst_gnt;
    logic        w_data_gnt;
    logic        w_inst_cap;
    logic        w_data_cap;

    // Arbitration: MEM first, IF forced through once it has lost enough times.
    // Reset masks every grant so nothing is issued while the block is held.
    always_comb begin
        w_both_req = inst_req & data_req;
        w_force_if = w_both_req & (r_starve_cnt == c_starve_limit);
        w_inst_gnt = ~rst & inst_req & (~data_req | w_force_if);
        w_data_gnt = ~rst & data_req & ~w_inst_gnt;
    end

    assign inst_gnt     = w_inst_gnt;
    assign data_gnt     = w_data_gnt;
    assign stallreq_if  = ~rst & inst_req & ~w_inst_gnt;
    assign stallreq_mem = ~rst & data_req & ~w_data_gnt;

    // SRAM request mux; fetch never writes and an idle port drives zeros
    always_comb begin
        sram_en    = w_inst_gnt | w_data_gnt;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0000_0000;
        sram_wdata = 32'h0000_0000;
        if (w_inst_gnt) begin
            sram_addr  = inst_addr;
        end else if (w_data_gnt) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    // Count consecutive lost cycles of a pending fetch, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (inst_req & ~w_inst_gnt) begin
            if (r_starve_cnt != c_starve_limit) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    // Owner state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= c_own_none;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Owner next state follows whoever was granted this cycle
    always_comb begin
        w_owner_nxt = c_own_none;
        if (w_inst_gnt) begin
            w_owner_nxt = c_own_inst;
        end else if (w_data_gnt) begin
            w_owner_nxt = (data_wen == 4'b0000) ? c_own_rd : c_own_wr;
        end
    end

    // Response routing: valid pulses and same-cycle bypass of SRAM read data
    always_comb begin
        inst_valid = 1'b0;
        data_valid = 1'b0;
        w_inst_cap = 1'b0;
        w_data_cap = 1'b0;
        inst_rdata = r_inst_hold;
        data_rdata = r_data_hold;
        if (rst) begin
            // In-flight response is dropped and the holds read as cleared
            inst_rdata = 32'h0000_0000;
            data_rdata = 32'h0000_0000;
        end else begin
            case (r_owner)
                c_own_inst: begin
                    inst_valid = 1'b1;
                    w_inst_cap = 1'b1;
                    inst_rdata = sram_rdata;
                end
                c_own_rd: begin
                    data_valid = 1'b1;
                    w_data_cap = 1'b1;
                    data_rdata = sram_rdata;
                end
                c_own_wr: begin
                    data_valid = 1'b1;
                end
                default: begin
                    inst_valid = 1'b0;
                end
            endcase
        end
    end

    // Hold registers keep read data stable for stalled stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_hold <= 32'h0000_0000;
            r_data_hold <= 32'h0000_0000;
        end else begin
            if (w_inst_cap) begin
                r_inst_hold <= sram_rdata;
            end
            if (w_data_cap) begin
                r_data_hold <= sram_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_conflict_cnt;
    logic [31:0] r_perf_starve_cnt;

    // Performance counters: request conflicts and forced fetch grants, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_conflict_cnt <= 32'd0;
            r_perf_starve_cnt   <= 32'd0;
        end else begin
            if (w_both_req) begin
                r_perf_conflict_cnt <= r_perf_conflict_cnt + 32'd1;
            end
            if (w_force_if) begin
                r_perf_starve_cnt <= r_perf_starve_cnt + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = r_perf_conflict_cnt;
    assign perf_starve_cnt   = r_perf_starve_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench for sram_port_arbiter: vector table for
//               the starvation pattern, directed corner sequences, and random
//               traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stallreq_if;
    logic        stallreq_mem;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_gnt     (inst_gnt),
        .inst_valid   (inst_valid),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_gnt     (data_gnt),
        .data_valid   (data_valid),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_starve_cnt   (perf_starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who answers next cycle, and the hold values
    int          m_starve;
    int          m_owner;      // 0 none, 1 fetch, 2 data read, 3 data write
    logic [31:0] m_ihold;
    logic [31:0] m_dhold;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic [31:0] srd;
        logic        e_igt;
        logic        e_dgt;
        logic        e_iv;
        logic        e_dv;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        e_sif;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model for the current inputs, then
    // advance the model as the clock edge will.
    task automatic model_step();
        logic        ig, dg;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wd;
        if (rst) begin
            ig = 1'b0; dg = 1'b0;
        end else begin
            ig = inst_req && (!data_req || m_starve == LIMIT);
            dg = data_req && !ig;
        end
        e_wen  = dg ? data_wen : 4'b0000;
        e_addr = ig ? inst_addr : (dg ? data_addr : 32'h0);
        e_wd   = dg ? data_wdata : 32'h0;
        chk("m_inst_gnt",   {31'h0, inst_gnt},   {31'h0, ig});
        chk("m_data_gnt",   {31'h0, data_gnt},   {31'h0, dg});
        chk("m_sram_en",    {31'h0, sram_en},    {31'h0, ig | dg});
        chk("m_sram_wen",   {28'h0, sram_wen},   {28'h0, e_wen});
        chk("m_sram_addr",  sram_addr,           e_addr);
        chk("m_sram_wdata", sram_wdata,          e_wd);
        chk("m_stall_if",   {31'h0, stallreq_if},  {31'h0, !rst && inst_req && !ig});
        chk("m_stall_mem",  {31'h0, stallreq_mem}, {31'h0, !rst && data_req && !dg});
        chk("m_inst_valid", {31'h0, inst_valid}, {31'h0, !rst && m_owner == 1});
        chk("m_data_valid", {31'h0, data_valid}, {31'h0, !rst && m_owner >= 2});
        chk("m_inst_rdata", inst_rdata, rst ? 32'h0 : (m_owner == 1 ? sram_rdata : m_ihold));
        chk("m_data_rdata", data_rdata, rst ? 32'h0 : (m_owner == 2 ? sram_rdata : m_dhold));
        if (rst) begin
            m_starve = 0; m_owner = 0; m_ihold = 32'h0; m_dhold = 32'h0;
        end else begin
            if (m_owner == 1) m_ihold = sram_rdata;
            if (m_owner == 2) m_dhold = sram_rdata;
            m_owner  = ig ? 1 : (dg ? ((data_wen == 4'b0000) ? 2 : 3) : 0);
            m_starve = (inst_req && !ig) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end
    endtask

    task automatic fin();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        sram_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            fin();
        end
        rst = 1'b0;
    endtask

    logic [31:0] saved;

    initial begin
        // Starvation pattern with both requesters held for ten cycles,
        // followed by one idle cycle to observe the last response.
        for (int k = 0; k < 11; k++) begin
            tbl[k].ireq  = (k < 10);
            tbl[k].dreq  = (k < 10);
            tbl[k].srd   = 32'h1000 + k;
            tbl[k].e_igt = (k == 4 || k == 9);
            tbl[k].e_dgt = (k < 10) && !(k == 4 || k == 9);
            tbl[k].e_iv  = (k == 5 || k == 10);
            tbl[k].e_dv  = (k >= 1 && k <= 9 && k != 5);
            tbl[k].e_ird = (k < 5) ? 32'h0 : ((k < 10) ? 32'h1005 : 32'h100A);
            tbl[k].e_drd = (k == 0) ? 32'h0 : ((k == 5) ? 32'h1004 : ((k == 10) ? 32'h1009 : 32'h1000 + k));
            tbl[k].e_sif = (k < 10) && !(k == 4 || k == 9);
        end

        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_sram_en", {31'h0, sram_en}, 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        fin();

        // Table: starvation guard
        for (int k = 0; k < 11; k++) begin
            inst_req = tbl[k].ireq; inst_addr = 32'h0000_0100;
            data_req = tbl[k].dreq; data_addr = 32'h0000_0200; data_wen = 4'h0;
            sram_rdata = tbl[k].srd;
            @(negedge clk);
            chk($sformatf("t%0d_inst_gnt", k),   {31'h0, inst_gnt},    {31'h0, tbl[k].e_igt});
            chk($sformatf("t%0d_data_gnt", k),   {31'h0, data_gnt},    {31'h0, tbl[k].e_dgt});
            chk($sformatf("t%0d_inst_valid", k), {31'h0, inst_valid},  {31'h0, tbl[k].e_iv});
            chk($sformatf("t%0d_data_valid", k), {31'h0, data_valid},  {31'h0, tbl[k].e_dv});
            chk($sformatf("t%0d_inst_rdata", k), inst_rdata, tbl[k].e_ird);
            chk($sformatf("t%0d_data_rdata", k), data_rdata, tbl[k].e_drd);
            chk($sformatf("t%0d_stall_if", k),   {31'h0, stallreq_if}, {31'h0, tbl[k].e_sif});
            fin();
        end
`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        chk("perf_conflict", perf_conflict_cnt, 32'd10);
        chk("perf_starve",   perf_starve_cnt,   32'd2);
        @(posedge clk); #1;
`endif

        // IF-only read with hold after the request drops
        idle_inputs();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        @(negedge clk);
        chk("if_gnt", {31'h0, inst_gnt}, 32'h1);
        chk("if_sram_addr", sram_addr, 32'hBFC0_0000);
        chk("if_sram_wen", {28'h0, sram_wen}, 32'h0);
        fin();
        inst_req = 1'b0; sram_rdata = 32'h3C1D_0001;
        @(negedge clk);
        chk("if_valid", {31'h0, inst_valid}, 32'h1);
        chk("if_rdata", inst_rdata, 32'h3C1D_0001);
        fin();
        sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("if_hold_valid", {31'h0, inst_valid}, 32'h0);
        chk("if_hold_rdata", inst_rdata, 32'h3C1D_0001);
        fin();

        // Conflict: data wins, fetch follows once data drops
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_wen = 4'h0;
        @(negedge clk);
        chk("cf_data_gnt", {31'h0, data_gnt}, 32'h1);
        chk("cf_stall_if", {31'h0, stallreq_if}, 32'h1);
        chk("cf_sram_addr", sram_addr, 32'h8000_1000);
        fin();
        data_req = 1'b0; sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("cf_data_valid", {31'h0, data_valid}, 32'h1);
        chk("cf_data_rdata", data_rdata, 32'h1234_5678);
        chk("cf_inst_gnt", {31'h0, inst_gnt}, 32'h1);
        fin();
        inst_req = 1'b0;
        @(negedge clk);
        fin();

        // Write: byte enables forwarded, data hold untouched
        saved = data_rdata;
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_2000; data_wdata = 32'h0000_BEEF;
        @(negedge clk);
        chk("wr_sram_wen", {28'h0, sram_wen}, 32'h3);
        chk("wr_sram_wdata", sram_wdata, 32'h0000_BEEF);
        fin();
        data_req = 1'b0; data_wen = 4'h0; sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("wr_data_valid", {31'h0, data_valid}, 32'h1);
        chk("wr_data_rdata", data_rdata, saved);
        fin();

        // Reset in the cycle after a read grant discards the response
        data_req = 1'b1; data_addr = 32'h8000_3000;
        @(negedge clk);
        chk("rr_data_gnt", {31'h0, data_gnt}, 32'h1);
        fin();
        data_req = 1'b0; rst = 1'b1; sram_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("rr_data_valid", {31'h0, data_valid}, 32'h0);
        chk("rr_data_rdata", data_rdata, 32'h0);
        fin();
        rst = 1'b0;
        @(negedge clk);
        chk("rr_after_valid", {31'h0, data_valid | inst_valid}, 32'h0);
        chk("rr_after_rdata", data_rdata | inst_rdata, 32'h0);
        chk("rr_after_en", {31'h0, sram_en}, 32'h0);
        fin();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            inst_req   = ($urandom_range(0, 9) < 6);
            data_req   = ($urandom_range(0, 9) < 6);
            inst_addr  = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            sram_rdata = $urandom;
            @(negedge clk);
            fin();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
